// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC multicycle control path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sisc_pkg;

  // Opcode values as they appear in instr[31:28]
  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_REG_OP = 4'h1;
  localparam logic [3:0] OP_REG_IM = 4'h2;
  localparam logic [3:0] OP_BRA    = 4'h4;
  localparam logic [3:0] OP_BRR    = 4'h5;
  localparam logic [3:0] OP_BNE    = 4'h6;
  localparam logic [3:0] OP_BNR    = 4'h7;
  localparam logic [3:0] OP_LOD    = 4'h8;
  localparam logic [3:0] OP_STR    = 4'h9;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // ALU function selects
  localparam logic [1:0] ALU_RR   = 2'b00;
  localparam logic [1:0] ALU_RI   = 2'b01;
  localparam logic [1:0] ALU_ADDR = 2'b10;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_START0  = 4'd0,
    ST_START1  = 4'd1,
    ST_FETCH   = 4'd2,
    ST_DECODE  = 4'd3,
    ST_EXECUTE = 4'd4,
    ST_MEM     = 4'd5,
    ST_WB      = 4'd6,
    ST_HALT    = 4'd7,
    ST_ERR     = 4'd8
  } state_t;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluation: classifies the opcode and tests stat against mm.
// Latency: purely combinational.
// Backpressure: none.
module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int MM_W   = 4,
  parameter int STAT_W = 4
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [MM_W-1:0]   mm,
  input  logic [STAT_W-1:0] stat,
  output logic              is_branch,
  output logic              taken,
  output logic              br_abs
);

  logic any_set;
  assign any_set = |(stat & STAT_W'(mm));

  // BRA/BRR branch when any masked flag is set, BNE/BNR when none are
  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    br_abs    = 1'b0;
    case (opcode)
      OP_W'(OP_BRA): begin is_branch = 1'b1; taken = any_set;  br_abs = 1'b1; end
      OP_W'(OP_BRR): begin is_branch = 1'b1; taken = any_set;  br_abs = 1'b0; end
      OP_W'(OP_BNE): begin is_branch = 1'b1; taken = !any_set; br_abs = 1'b1; end
      OP_W'(OP_BNR): begin is_branch = 1'b1; taken = !any_set; br_abs = 1'b0; end
      default:       ;
    endcase
  end

endmodule

// File: rtl/sisc_mc_ctrl.sv
// Multicycle SISC control FSM: fetch/decode/execute/mem/writeback with req/ack memory port.
// Latency: 4 clocks for a zero-wait register op; each cycle without mem_ack adds one.
// Backpressure: holds in FETCH/MEM until mem_ack; SISC_CTRL_TIMEOUT_EN bounds the wait and enters ERR.
module sisc_mc_ctrl
  import sisc_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int MM_W     = 4,
  parameter int STAT_W   = 4,
  parameter int ALU_OP_W = 2,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic [OP_W-1:0]     opcode,
  input  logic [MM_W-1:0]     mm,
  input  logic [STAT_W-1:0]   stat,
  input  logic                mem_ack,
  output logic                rf_we,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                wb_sel,
  output logic                br_sel,
  output logic                pc_sel,
  output logic                pc_write,
  output logic                pc_rst,
  output logic                ir_load,
  output logic                rb_sel,
  output logic                mem_req,
  output logic                mem_we,
  output logic                halted,
  output logic                bus_err
);

  state_t state;

  logic is_branch, taken, br_abs;

  sisc_br_cond #(
    .OP_W   (OP_W),
    .MM_W   (MM_W),
    .STAT_W (STAT_W)
  ) u_br_cond (
    .opcode    (opcode),
    .mm        (mm),
    .stat      (stat),
    .is_branch (is_branch),
    .taken     (taken),
    .br_abs    (br_abs)
  );

  logic is_reg, is_regim, is_lod, is_str, is_hlt, is_mem;
  assign is_reg   = (opcode == OP_W'(OP_REG_OP));
  assign is_regim = (opcode == OP_W'(OP_REG_IM));
  assign is_lod   = (opcode == OP_W'(OP_LOD));
  assign is_str   = (opcode == OP_W'(OP_STR));
  assign is_hlt   = (opcode == OP_W'(OP_HLT));
  assign is_mem   = is_lod | is_str;

  logic wait_expired;

`ifdef SISC_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Expires on the TIMEOUT-th consecutive cycle without an ack
  assign wait_expired = !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Count unacknowledged wait cycles; any other cycle clears, so entry to FETCH/MEM starts at 0
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      wait_cnt <= '0;
    end else if ((state == ST_FETCH || state == ST_MEM) && !mem_ack) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign wait_expired = 1'b0;
`endif

  // State sequencing; reset wins from any state, including mid-access
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state <= ST_START0;
    end else begin
      case (state)
        ST_START0:  state <= ST_START1;
        ST_START1:  state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ack)           state <= ST_DECODE;
          else if (wait_expired) state <= ST_ERR;
        end
        ST_DECODE: begin
          if (is_hlt)                          state <= ST_HALT;
          else if (is_reg || is_regim || is_mem) state <= ST_EXECUTE;
          else                                 state <= ST_FETCH;
        end
        ST_EXECUTE: state <= is_mem ? ST_MEM : ST_WB;
        ST_MEM: begin
          if (mem_ack)           state <= is_str ? ST_FETCH : ST_WB;
          else if (wait_expired) state <= ST_ERR;
        end
        ST_WB:      state <= ST_FETCH;
        ST_HALT:    state <= ST_HALT;
        ST_ERR:     state <= ST_ERR;
        default:    state <= ST_START0;
      endcase
    end
  end

  // ALU function for the instruction held in IR during EXECUTE/WRITEBACK
  logic [ALU_OP_W-1:0] exec_alu;
  always_comb begin
    exec_alu = ALU_OP_W'(ALU_RR);
    if (is_regim)    exec_alu = ALU_OP_W'(ALU_RI);
    else if (is_mem) exec_alu = ALU_OP_W'(ALU_ADDR);
  end

  // Datapath controls from state, qualified by mem_ack in FETCH and by branch outcome in DECODE
  always_comb begin
    rf_we    = 1'b0;
    alu_op   = '0;
    wb_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_sel   = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    ir_load  = 1'b0;
    rb_sel   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    bus_err  = 1'b0;
    case (state)
      ST_START0, ST_START1: pc_rst = 1'b1;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
      end
      ST_DECODE: begin
        if (is_branch && taken) begin
          pc_sel   = 1'b1;
          pc_write = 1'b1;
          br_sel   = br_abs;
        end
      end
      ST_EXECUTE: alu_op = exec_alu;
      ST_MEM: begin
        mem_req = 1'b1;
        alu_op  = ALU_OP_W'(ALU_ADDR);
        mem_we  = is_str;
        rb_sel  = is_str;
      end
      ST_WB: begin
        rf_we  = 1'b1;
        alu_op = exec_alu;
        wb_sel = is_lod;
      end
      ST_HALT: halted = 1'b1;
`ifdef SISC_CTRL_TIMEOUT_EN
      ST_ERR:  bus_err = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_mc_ctrl.sv
// Directed bench for sisc_mc_ctrl with a queue-based scoreboard.
// Stimulus pushes the expected output vector per cycle; a negedge monitor pops and compares.
// Timeout scenario is selected by SISC_CTRL_TIMEOUT_EN, matching the DUT build.
module tb_sisc_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_f;
    logic [3:0] opcode, mm, stat;
    logic       mem_ack;
    logic       rf_we, wb_sel, br_sel, pc_sel, pc_write, pc_rst, ir_load;
    logic       rb_sel, mem_req, mem_we, halted, bus_err;
    logic [1:0] alu_op;

    always #5 clk = ~clk;

    sisc_mc_ctrl #(
        .OP_W(4), .MM_W(4), .STAT_W(4), .ALU_OP_W(2), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .mem_ack(mem_ack), .rf_we(rf_we), .alu_op(alu_op), .wb_sel(wb_sel),
        .br_sel(br_sel), .pc_sel(pc_sel), .pc_write(pc_write), .pc_rst(pc_rst),
        .ir_load(ir_load), .rb_sel(rb_sel), .mem_req(mem_req), .mem_we(mem_we),
        .halted(halted), .bus_err(bus_err)
    );

    // Output vector: {rf_we, alu_op, wb_sel, br_sel, pc_sel, pc_write, pc_rst,
    //                 ir_load, rb_sel, mem_req, mem_we, halted, bus_err}
    localparam logic [13:0] NONE = 14'h0000;
    localparam logic [13:0] RF   = 14'h2000;
    localparam logic [13:0] ADDR = 14'h1000;
    localparam logic [13:0] RI   = 14'h0800;
    localparam logic [13:0] WBS  = 14'h0400;
    localparam logic [13:0] BRS  = 14'h0200;
    localparam logic [13:0] PCS  = 14'h0100;
    localparam logic [13:0] PCW  = 14'h0080;
    localparam logic [13:0] PCR  = 14'h0040;
    localparam logic [13:0] IRL  = 14'h0020;
    localparam logic [13:0] RB   = 14'h0010;
    localparam logic [13:0] REQ  = 14'h0008;
    localparam logic [13:0] WE   = 14'h0004;
    localparam logic [13:0] HLT  = 14'h0002;
    localparam logic [13:0] ERR  = 14'h0001;

    logic [13:0] act;
    assign act = {rf_we, alu_op, wb_sel, br_sel, pc_sel, pc_write, pc_rst,
                  ir_load, rb_sel, mem_req, mem_we, halted, bus_err};

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Monitor: compare every scheduled expectation away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %b expected %b", n, act, e);
            end
        end
    end

    // One cycle: drive inputs just after the edge, schedule the expected outputs, advance
    task automatic step(input logic r, input logic [3:0] op, input logic [3:0] m,
                        input logic [3:0] s, input logic ack, input logic [13:0] e,
                        input string n);
        rst_f   = r;
        opcode  = op;
        mm      = m;
        stat    = s;
        mem_ack = ack;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    // Reset release: START0 then START1 with pc_rst
    task automatic boot();
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, PCR, "boot_start0");
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, PCR, "boot_start1");
    endtask

    // Zero-wait fetch of the next instruction
    task automatic fetch(input string n);
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, REQ | IRL | PCW, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_f = 1'b0; opcode = '0; mm = '0; stat = '0; mem_ack = 1'b0;
        @(posedge clk);
        #1;

        // Reset held 3 clocks, then release
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, PCR, "reset_hold");
        boot();

        // REG_OP with two wait cycles before ack
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, REQ, "regop_wait1");
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, REQ, "regop_wait2");
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, REQ | IRL | PCW, "regop_ack");
        step(1'b1, 4'h1, 4'h0, 4'h0, 1'b1, NONE, "regop_decode");
        step(1'b1, 4'h1, 4'h0, 4'h0, 1'b0, NONE, "regop_exec");
        step(1'b1, 4'h1, 4'h0, 4'h0, 1'b0, RF, "regop_wb");

        // Branches: BRA taken/untaken, BRR taken, BNE taken, BNR taken
        fetch("bra_fetch");
        step(1'b1, 4'h4, 4'b0010, 4'b0010, 1'b0, PCS | PCW | BRS, "bra_taken");
        fetch("bra2_fetch");
        step(1'b1, 4'h4, 4'b0010, 4'b0100, 1'b0, NONE, "bra_untaken");
        fetch("brr_fetch");
        step(1'b1, 4'h5, 4'b0011, 4'b0010, 1'b0, PCS | PCW, "brr_taken");
        fetch("bne_fetch");
        step(1'b1, 4'h6, 4'b0001, 4'b0010, 1'b0, PCS | PCW | BRS, "bne_taken");
        fetch("bne2_fetch");
        step(1'b1, 4'h6, 4'b0010, 4'b0010, 1'b0, NONE, "bne_untaken");
        fetch("bnr_fetch");
        step(1'b1, 4'h7, 4'b0010, 4'b0100, 1'b0, PCS | PCW, "bnr_taken");

        // NOOP and an unassigned opcode both return to FETCH
        fetch("noop_fetch");
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, NONE, "noop_decode");
        fetch("op3_fetch");
        step(1'b1, 4'h3, 4'h0, 4'h0, 1'b0, NONE, "op3_decode");

        // REG_IM, stray ack in EXECUTE ignored
        fetch("regim_fetch");
        step(1'b1, 4'h2, 4'h0, 4'h0, 1'b0, NONE, "regim_decode");
        step(1'b1, 4'h2, 4'h0, 4'h0, 1'b1, RI, "regim_exec");
        step(1'b1, 4'h2, 4'h0, 4'h0, 1'b1, RF | RI, "regim_wb");

        // LOD with immediate ack
        fetch("lod_fetch");
        step(1'b1, 4'h8, 4'h0, 4'h0, 1'b0, NONE, "lod_decode");
        step(1'b1, 4'h8, 4'h0, 4'h0, 1'b0, ADDR, "lod_exec");
        step(1'b1, 4'h8, 4'h0, 4'h0, 1'b1, REQ | ADDR, "lod_mem");
        step(1'b1, 4'h8, 4'h0, 4'h0, 1'b0, RF | ADDR | WBS, "lod_wb");

        // STR with one wait, no writeback
        fetch("str_fetch");
        step(1'b1, 4'h9, 4'h0, 4'h0, 1'b0, NONE, "str_decode");
        step(1'b1, 4'h9, 4'h0, 4'h0, 1'b0, ADDR, "str_exec");
        step(1'b1, 4'h9, 4'h0, 4'h0, 1'b0, REQ | ADDR | WE | RB, "str_mem_wait");
        step(1'b1, 4'h9, 4'h0, 4'h0, 1'b1, REQ | ADDR | WE | RB, "str_mem_ack");
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, REQ, "str_back_fetch");

        // Reset during MEM wait: request drops on the reset edge
        fetch("rstmem_fetch");
        step(1'b1, 4'h8, 4'h0, 4'h0, 1'b0, NONE, "rstmem_decode");
        step(1'b1, 4'h8, 4'h0, 4'h0, 1'b0, ADDR, "rstmem_exec");
        step(1'b1, 4'h8, 4'h0, 4'h0, 1'b0, REQ | ADDR, "rstmem_wait");
        step(1'b0, 4'h8, 4'h0, 4'h0, 1'b0, REQ | ADDR, "rstmem_assert");
        boot();
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, REQ, "rstmem_refetch");

        // HLT: halted for 50 clocks regardless of ack, leaves only via reset
        fetch("hlt_fetch");
        step(1'b1, 4'hF, 4'h0, 4'h0, 1'b0, NONE, "hlt_decode");
        for (int i = 0; i < 50; i++)
            step(1'b1, 4'hF, 4'h0, 4'h0, logic'(i[0]), HLT, "hlt_hold");
        checks++;
        if (halted !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL hlt_direct: got halted=%b mem_req=%b expected halted=1 mem_req=0",
                     halted, mem_req);
        end
        step(1'b0, 4'hF, 4'h0, 4'h0, 1'b0, HLT, "hlt_rst_assert");
        boot();
        checks++;
        if (pc_rst !== 1'b0 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL boot_direct: got pc_rst=%b mem_req=%b expected pc_rst=0 mem_req=1",
                     pc_rst, mem_req);
        end

`ifdef SISC_CTRL_TIMEOUT_EN
        // TIMEOUT=4: four unacknowledged fetch cycles, then ERR until reset
        for (int i = 0; i < 4; i++) step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, REQ, "to_wait");
        for (int i = 0; i < 5; i++) step(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, ERR, "to_err");
        step(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, ERR, "to_rst_assert");
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, PCR, "to_start0");
`else
        // Without the timeout the fetch waits indefinitely and bus_err stays low
        for (int i = 0; i < 100; i++) step(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, REQ, "fetch_wait_forever");
        step(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, REQ | IRL | PCW, "fetch_late_ack");
`endif

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
